apb_master: RTL and testbench

//  APB initiator driving the register-file slaves (number-in-group/date/surname/name bank at 0x0/0x4/0x8/0xC).

---
 rtl/apb_pkg.sv | 25 ++
 rtl/apb_cmd_fifo.sv | 59 +++++
 rtl/apb_master.sv | 170 +++++++++++++++++
 tb/tb_apb_master.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared types for the APB initiator: FSM states, queued command layout and
// the register-file offsets of the slaves this master talks to.
package apb_pkg;

  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_t;

  typedef struct packed {
    logic                  write;
    logic [APB_ADDR_W-1:0] addr;
    logic [APB_DATA_W-1:0] wdata;
  } apb_cmd_t;

  localparam logic [APB_ADDR_W-1:0] REG_NUM     = 32'h0;
  localparam logic [APB_ADDR_W-1:0] REG_DATE    = 32'h4;
  localparam logic [APB_ADDR_W-1:0] REG_SURNAME = 32'h8;
  localparam logic [APB_ADDR_W-1:0] REG_NAME    = 32'hC;

endpackage

// File: rtl/apb_cmd_fifo.sv
// Synchronous first-word-fall-through command FIFO; the head entry is always
// visible on rd_data so the master can load the bus in the same cycle it pops.
module apb_cmd_fifo
  import apb_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = apb_cmd_t
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  T     wr_data,
  input  logic pop,
  output T     rd_data,
  output logic full,
  output logic empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  T                 mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign rd_data = mem_q[rd_ptr_q];

  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
    rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
    count_d  = count_q;
    if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
    else if (!do_push && do_pop) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/apb_master.sv
// APB initiator: queued read/write commands run as SETUP->ACCESS transfers,
// each producing one response pulse (data or timeout error).
module apb_master
  import apb_pkg::*;
#(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int ADDR_W         = APB_ADDR_W,
  parameter int DATA_W         = APB_DATA_W
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic              rsp_write,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              busy,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

  cmd_t head;
  logic fifo_full, fifo_empty, pop;

  apb_cmd_fifo #(.DEPTH(FIFO_DEPTH), .T(cmd_t)) u_fifo (
    .clk     (PCLK),
    .rst     (PRESET),
    .push    (cmd_valid),
    .wr_data ('{write: cmd_write, addr: cmd_addr, wdata: cmd_wdata}),
    .pop     (pop),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  apb_state_t        state_q, state_d;
  logic              psel_q, psel_d, penable_q, penable_d, pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic [TO_W-1:0]   cnt_q, cnt_d;
  logic              rsp_valid_q, rsp_valid_d, rsp_write_q, rsp_write_d;
  logic              rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              load;

  assign cmd_ready = !fifo_full;
  assign busy      = (state_q != IDLE) || !fifo_empty;
  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;
  assign PWRITE    = pwrite_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_write = rsp_write_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

  always_comb begin
    state_d     = state_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    cnt_d       = cnt_q;
    rsp_valid_d = 1'b0;
    rsp_write_d = rsp_write_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    load        = 1'b0;

    unique case (state_q)
      IDLE: load = !fifo_empty;
      SETUP: begin
        penable_d = 1'b1;
        cnt_d     = '0;
        state_d   = ACCESS;
      end
      ACCESS: begin
        if (PREADY) begin
          rsp_valid_d = 1'b1;
          rsp_write_d = pwrite_q;
          rsp_rdata_d = pwrite_q ? '0 : PRDATA;
          rsp_err_d   = 1'b0;
          // Chain straight into the next SETUP so PSEL never drops between queued commands.
          load = !fifo_empty;
          if (fifo_empty) begin
            psel_d    = 1'b0;
            penable_d = 1'b0;
            state_d   = IDLE;
          end
        end else if (cnt_q == TO_LAST) begin
          rsp_valid_d = 1'b1;
          rsp_write_d = pwrite_q;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          state_d     = IDLE;
        end else begin
          cnt_d = cnt_q + TO_W'(1);
        end
      end
      default: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        state_d   = IDLE;
      end
    endcase

    if (load) begin
      pwrite_d  = head.write;
      paddr_d   = head.addr;
      pwdata_d  = head.wdata;
      psel_d    = 1'b1;
      penable_d = 1'b0;
      state_d   = SETUP;
    end
  end

  assign pop = load;

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q     <= IDLE;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// Bench for apb_master: stub register-file slave with programmable waits,
// never-ready and stray-PREADY modes, plus a queue-based reference model.
module tb_apb_master;
  import apb_pkg::*;

  localparam int DEPTH = 4;
  localparam int TO    = 16;
  localparam int AW    = 32;
  localparam int DW    = 32;

  logic          PCLK = 1'b0, PRESET = 1'b1;
  logic          cmd_valid = 1'b0, cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic          cmd_ready, rsp_valid, rsp_write, rsp_err, busy;
  logic          PSEL, PENABLE, PWRITE, PREADY;
  logic [DW-1:0] rsp_rdata, PWDATA, PRDATA;
  logic [AW-1:0] PADDR;

  apb_master #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TO), .ADDR_W(AW), .DATA_W(DW)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .busy(busy),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY)
  );

  always #5 PCLK = ~PCLK;

  // Stub slave: 4-register bank decoded on PADDR[3:2].
  int unsigned   wait_cfg = 1;
  bit            never_ready = 0, stray = 0;
  int unsigned   wcnt = 0;
  logic [DW-1:0] slv_mem [4];
  logic          acc;

  assign acc = PSEL && PENABLE;
  always_comb PREADY = acc ? (!never_ready && wcnt == wait_cfg) : stray;
  always_comb PRDATA = slv_mem[PADDR[3:2]];

  always @(posedge PCLK) begin
    if (!acc) wcnt <= 0;
    else      wcnt <= wcnt + 1;
    if (acc && PREADY && PWRITE) slv_mem[PADDR[3:2]] <= PWDATA;
  end

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: commands in acceptance order with the slave behaviour
  // in force; the register contents are resolved when each response arrives.
  typedef struct {
    bit            write;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    bit            tmo;
    int unsigned   waits;
  } exp_t;

  exp_t          iss_q[$], rsp_q[$];
  exp_t          mon_e;
  logic [DW-1:0] ref_mem [4];

  bit            prev_psel = 0, prev_pen = 0, prev_write = 0;
  logic [AW-1:0] prev_addr = '0;
  logic [DW-1:0] prev_wdata = '0;
  int unsigned   acc_run = 0, last_acc_len = 0, b2b_cnt = 0, rsp_cnt = 0, cyc = 0;

  always @(posedge PCLK) cyc <= cyc + 1;

  always @(negedge PCLK) begin
    if (PRESET) begin
      prev_psel = 0;
      prev_pen  = 0;
      acc_run   = 0;
    end else begin
      if (PSEL && PENABLE) acc_run++;
      else if (acc_run != 0) begin
        last_acc_len = acc_run;
        acc_run      = 0;
      end
      if (prev_psel && !prev_pen) chk("setup_one_cycle", {PSEL, PENABLE}, 2'b11);
      if (PSEL && PENABLE && prev_psel && prev_pen) begin
        chk("hold_addr", PADDR, prev_addr);
        chk("hold_ctl", {PWRITE, PWDATA}, {prev_write, prev_wdata});
      end
      if (PSEL && !PENABLE) begin
        if (prev_psel && prev_pen) b2b_cnt++;
        if (iss_q.size() == 0) chk("unexpected_setup", 1, 0);
        else begin
          mon_e = iss_q.pop_front();
          chk("issue_addr", PADDR, mon_e.addr);
          chk("issue_write", PWRITE, mon_e.write);
          if (mon_e.write) chk("issue_wdata", PWDATA, mon_e.wdata);
        end
      end
      if (rsp_valid) begin
        rsp_cnt++;
        if (rsp_q.size() == 0) chk("spurious_rsp", 1, 0);
        else begin
          mon_e = rsp_q.pop_front();
          chk("rsp_write", rsp_write, mon_e.write);
          chk("rsp_err", rsp_err, mon_e.tmo);
          if (mon_e.tmo) begin
            chk("tmo_len", last_acc_len, TO);
            chk("tmo_bus_idle", {PSEL, PENABLE}, 2'b00);
            chk("tmo_rdata", rsp_rdata, 0);
          end else begin
            chk("access_len", last_acc_len, mon_e.waits + 1);
            if (mon_e.write) begin
              ref_mem[mon_e.addr[3:2]] = mon_e.wdata;
              chk("wr_rdata_zero", rsp_rdata, 0);
            end else begin
              chk("rsp_rdata", rsp_rdata, ref_mem[mon_e.addr[3:2]]);
            end
          end
        end
      end
      prev_psel  = PSEL;
      prev_pen   = PENABLE;
      prev_write = PWRITE;
      prev_addr  = PADDR;
      prev_wdata = PWDATA;
    end
  end

  // Called at a negedge; returns at the negedge following acceptance.
  task automatic send(input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    exp_t e;
    bit   ok;
    bit   done;
    done    = 0;
    e.write = w;
    e.addr  = a;
    e.wdata = d;
    e.tmo   = never_ready;
    e.waits = wait_cfg;
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    for (int i = 0; i < 300 && !done; i++) begin
      ok = cmd_ready;
      @(posedge PCLK);
      if (ok) begin
        iss_q.push_back(e);
        rsp_q.push_back(e);
        done = 1;
      end
      @(negedge PCLK);
    end
    cmd_valid = 1'b0;
    if (!done) chk("cmd_accept_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    int i;
    i = 0;
    while ((busy || rsp_q.size() != 0) && i < 2000) begin
      @(negedge PCLK);
      i++;
    end
    chk("drain", {busy, rsp_q.size() != 0}, 2'b00);
    @(negedge PCLK);
  endtask

  task automatic rsp_latency(input string tag, input int unsigned exp_lat);
    int unsigned t0;
    int          i;
    t0 = cyc;
    i  = 0;
    while (!rsp_valid && i < 100) begin
      @(negedge PCLK);
      i++;
    end
    chk(tag, cyc - t0, exp_lat);
  endtask

  initial begin
    int unsigned r0, b0, n;
    for (int i = 0; i < 4; i++) begin
      slv_mem[i] = '0;
      ref_mem[i] = '0;
    end
    repeat (2) @(negedge PCLK);
    chk("rst_bus", {PSEL, PENABLE, PWRITE}, 3'b000);
    chk("rst_paddr", PADDR, 0);
    chk("rst_rsp", {rsp_valid, rsp_err, rsp_write}, 3'b000);
    chk("rst_busy_ready", {busy, cmd_ready}, 2'b01);
    PRESET = 1'b0;
    @(negedge PCLK);

    // Basic write/read; rsp_valid is seen one negedge before the edge that samples it.
    wait_cfg = 0;
    send(1, REG_NUM, 32'h0000_0007);
    rsp_latency("lat_zero_wait", 3);
    wait_idle();
    wait_cfg = 1;
    send(0, REG_NUM, '0);
    rsp_latency("lat_one_wait", 4);
    chk("read_back_num", rsp_rdata, 32'h0000_0007);
    wait_idle();

    // FIFO fill behind a slow transfer, then back-to-back issue.
    wait_cfg = 3;
    b0 = b2b_cnt;
    send(0, REG_NUM, '0);
    send(1, REG_NUM, 32'h0000_0007);
    send(1, REG_DATE, 32'h0112_2024);
    send(1, REG_SURNAME, 32'h4956_414E);
    send(1, REG_NAME, 32'h5045_5452);
    chk("fifo_full_ready", cmd_ready, 0);
    wait_idle();
    chk("back_to_back", b2b_cnt - b0, 4);
    wait_cfg = 1;
    send(0, REG_NUM, '0);
    send(0, REG_DATE, '0);
    send(0, REG_SURNAME, '0);
    send(0, REG_NAME, '0);
    wait_idle();

    // Timeouts: the write must not land, the read returns zero with error.
    never_ready = 1;
    send(1, REG_NAME, 32'h1234_5678);
    send(0, REG_DATE, '0);
    wait_idle();
    never_ready = 0;
    send(0, REG_NAME, '0);
    wait_idle();

    // Wait states on a read.
    send(1, REG_DATE, 32'hDEAD_BEEF);
    wait_idle();
    wait_cfg = 3;
    send(0, REG_DATE, '0);
    wait_idle();
    chk("deadbeef", rsp_rdata, 32'hDEAD_BEEF);

    // Reset during ACCESS with two commands queued.
    wait_cfg = 6;
    send(0, REG_NUM, '0);
    send(0, REG_DATE, '0);
    send(0, REG_NAME, '0);
    n = 0;
    while (!(PSEL && PENABLE) && n < 50) begin
      @(negedge PCLK);
      n++;
    end
    chk("reach_access", {PSEL, PENABLE}, 2'b11);
    r0 = rsp_cnt;
    PRESET = 1'b1;
    #1;
    chk("mid_rst_bus", {PSEL, PENABLE, rsp_valid}, 3'b000);
    chk("mid_rst_busy", {busy, cmd_ready}, 2'b01);
    iss_q.delete();
    rsp_q.delete();
    repeat (2) @(negedge PCLK);
    PRESET = 1'b0;
    repeat (12) @(negedge PCLK);
    chk("no_rsp_after_rst", rsp_cnt, r0);
    chk("idle_after_rst", {busy, PSEL}, 2'b00);

    // Stray PREADY outside ACCESS.
    stray    = 1;
    wait_cfg = 2;
    r0       = rsp_cnt;
    repeat (5) @(negedge PCLK);
    chk("stray_idle_no_rsp", rsp_cnt, r0);
    send(0, REG_NUM, '0);
    send(1, REG_SURNAME, 32'hA5A5_0001);
    wait_idle();
    stray = 0;

    // Randomized batches; waits fixed within a batch.
    for (int b = 0; b < 6; b++) begin
      wait_cfg = $urandom_range(0, 3);
      for (int k = 0; k < 8; k++) begin
        send($urandom_range(0, 1), $urandom, $urandom);
        repeat ($urandom_range(0, 2)) @(negedge PCLK);
      end
      wait_idle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
    $fatal(1);
  end

endmodule
